// File: rtl/spi_master_pkg.sv
// Shared types and constants for the SPI master transmit path.
package spi_master_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        TRANSMIT = 1'b1
    } tx_state_e;

    localparam logic SPI_STD  = 1'b0;
    localparam logic SPI_QUAD = 1'b1;

    localparam int unsigned WORD_EDGES_STD  = 32;
    localparam int unsigned WORD_EDGES_QUAD = 8;

endpackage

// File: rtl/spi_master_tx_cnt.sv
// Edge counter for the SPI transmit shifter: latches the per-transfer edge
// target at start and flags the final edge and FIFO word boundaries.
module spi_master_tx_cnt
    import spi_master_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 quad_start_i,
    input  logic [CNT_WIDTH-1:0] counter_in_i,
    input  logic                 quad_i,
    input  logic                 adv_i,
    output logic                 last_o,
    output logic                 boundary_o
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] target_q;
    logic [CNT_WIDTH-1:0] target_d;
    logic [CNT_WIDTH-1:0] word_mask;
    logic [CNT_WIDTH:0]   sum_w;

    // Quad mode sends four bits per edge, so the edge target is ceil(bits/4).
    always_comb begin
        sum_w    = {1'b0, counter_in_i} + (CNT_WIDTH+1)'(3);
        target_d = quad_start_i ? CNT_WIDTH'(sum_w >> 2) : counter_in_i;
    end

    assign word_mask  = quad_i ? CNT_WIDTH'(WORD_EDGES_QUAD - 1)
                               : CNT_WIDTH'(WORD_EDGES_STD - 1);
    assign last_o     = (cnt_q == (target_q - CNT_WIDTH'(1)));
    assign boundary_o = ((cnt_q & word_mask) == word_mask) && !last_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            target_q <= '0;
        end else if (start_i) begin
            cnt_q    <= '0;
            target_q <= target_d;
        end else if (adv_i) begin
            cnt_q    <= cnt_q + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/spi_master_tx.sv
// SPI master transmit shifter: pops FIFO words and shifts them out MSB-first.
// Quad (4-lane) mode is compiled in only when SPI_MASTER_TX_QUAD_EN is defined.
module spi_master_tx
    import spi_master_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  tx_edge_i,
    input  logic                  quad_mode_i,
    input  logic [CNT_WIDTH-1:0]  counter_in_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  data_valid_i,
    output logic                  data_ready_o,
    output logic                  sdo0_o,
    output logic                  sdo1_o,
    output logic                  sdo2_o,
    output logic                  sdo3_o,
    output logic                  clk_en_o,
    output logic                  tx_done_o
);

    tx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic                  quad_q, quad_d;
    logic                  quad_sel;
    logic                  tx_done_d;
    logic                  start;
    logic                  adv;
    logic                  last;
    logic                  boundary;
    logic                  stall;

`ifdef SPI_MASTER_TX_QUAD_EN
    assign quad_sel = quad_mode_i;
`else
    assign quad_sel = quad_mode_i & SPI_STD;
`endif

    // Waiting on the FIFO at a word boundary freezes the SPI clock and the shifter.
    assign stall    = (state_q == TRANSMIT) && boundary && !data_valid_i;
    assign clk_en_o = (state_q == TRANSMIT) && !stall;

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        quad_d       = quad_q;
        start        = 1'b0;
        adv          = 1'b0;
        tx_done_d    = 1'b0;
        data_ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                data_ready_o = en_i && (counter_in_i != '0);
                if (data_ready_o && data_valid_i) begin
                    start   = 1'b1;
                    sr_d    = data_i;
                    quad_d  = quad_sel;
                    state_d = TRANSMIT;
                end
            end
            TRANSMIT: begin
                data_ready_o = tx_edge_i && boundary;
                if (tx_edge_i && !stall) begin
                    if (last) begin
                        state_d   = IDLE;
                        tx_done_d = 1'b1;
                    end else if (boundary) begin
                        sr_d = data_i;
                        adv  = 1'b1;
                    end else begin
                        sr_d = (quad_q == SPI_QUAD) ? (sr_q << 4) : (sr_q << 1);
                        adv  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            quad_q    <= SPI_STD;
            tx_done_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            quad_q    <= quad_d;
            tx_done_o <= tx_done_d;
        end
    end

`ifdef SPI_MASTER_TX_QUAD_EN
    assign {sdo3_o, sdo2_o, sdo1_o, sdo0_o} = (quad_q == SPI_QUAD)
        ? sr_q[DATA_WIDTH-1 -: 4] : {3'b000, sr_q[DATA_WIDTH-1]};
`else
    assign sdo0_o = sr_q[DATA_WIDTH-1];
    assign sdo1_o = 1'b0;
    assign sdo2_o = 1'b0;
    assign sdo3_o = 1'b0;
`endif

    spi_master_tx_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start),
        .quad_start_i (quad_sel),
        .counter_in_i (counter_in_i),
        .quad_i       (quad_q),
        .adv_i        (adv),
        .last_o       (last),
        .boundary_o   (boundary)
    );

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: table-driven transfers plus stall,
// zero-count and mid-transfer reset sequences.
module tb_spi_master_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        tx_edge = 1'b0;
    logic        quad_mode = 1'b0;
    logic [15:0] counter_in = '0;
    logic [31:0] data;
    logic        data_valid;
    logic        data_ready;
    logic        sdo0, sdo1, sdo2, sdo3;
    logic        clk_en;
    logic        tx_done;
    logic [3:0]  lanes;

    logic [31:0] fmem [0:7];
    logic [31:0] wr_p = '0;
    logic [31:0] rd_p = '0;
    int          pops = 0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        quad;
        logic [15:0] nbits;
        logic [31:0] w0;
        logic [31:0] w1;
        int          npush;
        int          exp_edges;
        int          exp_pops;
        logic [15:0] first4;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    assign data_valid = (wr_p != rd_p);
    assign data       = fmem[rd_p[2:0]];
    assign lanes      = {sdo3, sdo2, sdo1, sdo0};

    always @(posedge clk) begin
        if (data_ready && data_valid) begin
            rd_p <= rd_p + 32'd1;
            pops <= pops + 1;
        end
    end

    spi_master_tx dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (en),
        .tx_edge_i    (tx_edge),
        .quad_mode_i  (quad_mode),
        .counter_in_i (counter_in),
        .data_i       (data),
        .data_valid_i (data_valid),
        .data_ready_o (data_ready),
        .sdo0_o       (sdo0),
        .sdo1_o       (sdo1),
        .sdo2_o       (sdo2),
        .sdo3_o       (sdo3),
        .clk_en_o     (clk_en),
        .tx_done_o    (tx_done)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        fmem[wr_p[2:0]] = w;
        wr_p = wr_p + 32'd1;
    endtask

    task automatic edge_pulse();
        tx_edge = 1'b1;
        @(posedge clk); #1;
        tx_edge = 1'b0;
        #1;
    endtask

    task automatic gap();
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic start_xfer(input logic q, input logic [15:0] n);
        quad_mode  = q;
        counter_in = n;
        en         = 1'b1;
        #1;
        chk("start_ready", {31'd0, data_ready}, 32'd1);
        @(posedge clk); #1;
        en = 1'b0;
        #1;
        chk("start_clk_en", {31'd0, clk_en}, 32'd1);
    endtask

    task automatic run_vec(input int idx);
        vec_t        v;
        logic        eq;
        int          w;
        int          edges;
        int          p0;
        logic [31:0] msr;
        logic [3:0]  explane;
        v = vecs[idx];
`ifdef SPI_MASTER_TX_QUAD_EN
        eq = v.quad;
`else
        eq = 1'b0;
`endif
        w = eq ? 8 : 32;
        if (v.npush > 0) push(v.w0);
        if (v.npush > 1) push(v.w1);
        p0 = pops;
        start_xfer(v.quad, v.nbits);
        msr   = v.w0;
        edges = 0;
        while (edges < 300) begin
            explane = eq ? msr[31:28] : {3'b000, msr[31]};
            chk($sformatf("v%0d_lanes_e%0d", idx, edges), {28'd0, lanes}, {28'd0, explane});
            if (edges < 4)
                chk($sformatf("v%0d_hand_e%0d", idx, edges), {28'd0, lanes},
                    {28'd0, v.first4[15-4*edges -: 4]});
            edge_pulse();
            edges++;
            if (tx_done) break;
            if (((edges - 1) % w) == (w - 1)) msr = v.w1;
            else msr = eq ? (msr << 4) : (msr << 1);
            gap();
        end
        chk($sformatf("v%0d_edges", idx), edges, v.exp_edges);
        chk($sformatf("v%0d_pops", idx), pops - p0, v.exp_pops);
        @(posedge clk); #2;
        chk($sformatf("v%0d_done_once", idx), {31'd0, tx_done}, 32'd0);
        chk($sformatf("v%0d_idle_clk_en", idx), {31'd0, clk_en}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;

        vecs[0] = '{1'b0, 16'd8,  32'hA500_0000, 32'h0, 0, 8, 1, 16'h1010};
        vecs[1] = '{1'b0, 16'd64, 32'hFFFF_0000, 32'h0000_FFFF, 2, 64, 2, 16'h1111};
`ifdef SPI_MASTER_TX_QUAD_EN
        vecs[2] = '{1'b1, 16'd32, 32'h1234_5678, 32'h0, 1, 8, 1, 16'h1234};
        vecs[3] = '{1'b1, 16'd10, 32'hABC0_0000, 32'h0, 1, 3, 1, 16'hABC0};
`else
        vecs[2] = '{1'b1, 16'd32, 32'h1234_5678, 32'h0, 1, 32, 1, 16'h0001};
        vecs[3] = '{1'b1, 16'd10, 32'hABC0_0000, 32'h0, 1, 10, 1, 16'h1010};
`endif
        vecs[4] = '{1'b0, 16'd33, 32'h0000_0001, 32'h8000_0000, 2, 33, 2, 16'h0000};

        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lanes", {28'd0, lanes}, 32'd0);
        chk("rst_clk_en", {31'd0, clk_en}, 32'd0);
        chk("rst_done", {31'd0, tx_done}, 32'd0);
        chk("rst_ready", {31'd0, data_ready}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // reset mid-transfer
        push(32'hFFFF_0000);
        p0 = pops;
        start_xfer(1'b0, 16'd16);
        repeat (5) begin
            edge_pulse();
            gap();
        end
        chk("pre_rst_lane", {28'd0, lanes}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_lanes", {28'd0, lanes}, 32'd0);
        chk("mid_rst_clk_en", {31'd0, clk_en}, 32'd0);
        chk("mid_rst_ready", {31'd0, data_ready}, 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("mid_rst_no_done", {31'd0, tx_done}, 32'd0);
        end
        chk("mid_rst_pops", pops - p0, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // zero bit count with a word waiting
        push(32'hA500_0000);
        p0 = pops;
        quad_mode  = 1'b0;
        counter_in = 16'd0;
        en         = 1'b1;
        #1;
        chk("zero_ready", {31'd0, data_ready}, 32'd0);
        repeat (5) begin
            @(posedge clk); #1;
            chk("zero_clk_en", {31'd0, clk_en}, 32'd0);
            chk("zero_done", {31'd0, tx_done}, 32'd0);
        end
        chk("zero_pops", pops - p0, 32'd0);
        en = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            run_vec(i);
            gap();
        end

        // FIFO underrun at the word boundary
        push(32'h0000_0001);
        p0 = pops;
        start_xfer(1'b0, 16'd40);
        for (int i = 0; i < 31; i++) begin
            edge_pulse();
            gap();
        end
        chk("stall_clk_en", {31'd0, clk_en}, 32'd0);
        chk("stall_lane", {28'd0, lanes}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            edge_pulse();
            chk("stall_ign_lane", {28'd0, lanes}, 32'd1);
            chk("stall_ign_clk_en", {31'd0, clk_en}, 32'd0);
            chk("stall_ign_done", {31'd0, tx_done}, 32'd0);
            gap();
        end
        chk("stall_pops", pops - p0, 32'd1);
        push(32'h8000_0000);
        #1;
        chk("stall_release", {31'd0, clk_en}, 32'd1);
        edge_pulse();
        chk("stall_pop2", pops - p0, 32'd2);
        chk("stall_new_msb", {28'd0, lanes}, 32'd1);
        gap();
        for (int i = 0; i < 7; i++) begin
            edge_pulse();
            chk("stall_tail_lane", {28'd0, lanes}, 32'd0);
            chk("stall_tail_done", {31'd0, tx_done}, 32'd0);
            gap();
        end
        edge_pulse();
        chk("stall_done", {31'd0, tx_done}, 32'd1);
        @(posedge clk); #2;
        chk("stall_done_once", {31'd0, tx_done}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
